// File: rtl/sipo_frame_rx_pkg.sv
// sipo_frame_rx_pkg: shared state encoding and parity sense for the serial frame receiver
package sipo_frame_rx_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
   localparam logic PARITY_EVEN = 1'b1;
endpackage

// File: rtl/sipo_shift.sv
// sipo_shift: n-bit shift-left register with synchronous clear and shift enable
module sipo_shift #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         clear_n,
   input  logic         clr,
   input  logic         en,
   input  logic         d,
   output logic [N-1:0] q
);
   // clear wins over shift; new bit enters the LSB
   always_ff @(posedge clk or negedge clear_n)
      if (!clear_n) q <= '0;
      else if (clr) q <= '0;
      else if (en) q <= {q[N-2:0], d};
endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: receives start/n data (MSB first)/even parity/stop frames into a valid/ready word
module sipo_frame_rx
   import sipo_frame_rx_pkg::*;
#(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         clear_n,
   input  logic         si,
   input  logic         bit_en,
   output logic [n-1:0] data,
   output logic         valid,
   input  logic         ready,
   output logic         busy,
   output logic         parity_err,
   output logic         frame_err,
   output logic         overrun
);
   localparam int CW = $clog2(n + 1);
   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           par_q, par_d;
   logic [n-1:0]   data_q, data_d, sh;
   logic           valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
   logic           sh_clr, sh_en, par_bad;

   sipo_shift #(.N(n)) u_shift (
      .clk(clk), .clear_n(clear_n), .clr(sh_clr), .en(sh_en), .d(si), .q(sh)
   );

   // even parity: data bits XOR parity bit must come out zero
   assign par_bad = (^{sh, par_q}) == PARITY_EVEN;

   // frame sequencing, error pulses and output word handoff
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      data_d  = data_q;
      valid_d = valid_q & ~ready;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = ovr_q;
      sh_clr  = 1'b0;
      sh_en   = 1'b0;
      if (bit_en) begin
         case (state_q)
            IDLE: if (!si) begin
               state_d = DATA;
               cnt_d   = '0;
               sh_clr  = 1'b1;
            end
            DATA: begin
               sh_en   = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_q == CW'(n - 1)) ? PARITY : DATA;
            end
            PARITY: begin
               par_d   = si;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               ferr_d  = !si;
               perr_d  = si && par_bad;
               if (si && !par_bad) begin
                  if (!valid_q || ready) begin
                     data_d  = sh;
                     valid_d = 1'b1;
                  end else
                     ovr_d = 1'b1;
               end
            end
         endcase
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge clear_n)
      if (!clear_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end

   assign data       = data_q;
   assign valid      = valid_q;
   assign busy       = state_q != IDLE;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: scoreboard bench driving whole frames against a frame-level model
module tb_sipo_frame_rx;
   logic       clk = 1'b0, clear_n = 1'b0, si = 1'b1, bit_en = 1'b0, ready = 1'b1;
   logic [7:0] data;
   logic       valid, busy, parity_err, frame_err, overrun;
   int         cmp = 0, bad = 0;
   logic [7:0] word_q[$];
   logic [1:0] err_q[$];
   logic       m_pending = 1'b0, m_ovr = 1'b0;
   logic [7:0] m_data = 8'h00;

   sipo_frame_rx #(.n(8)) dut (
      .clk(clk), .clear_n(clear_n), .si(si), .bit_en(bit_en), .data(data), .valid(valid),
      .ready(ready), .busy(busy), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // monitor: every handshake and every error pulse must match the oldest expectation
   always @(negedge clk) if (clear_n) begin
      if (valid && ready) begin
         if (word_q.size() == 0) begin
            cmp++; bad++;
            $display("FAIL spurious_word: got %0h expected none at %0t", data, $time);
         end else chk("word", data, word_q.pop_front());
      end
      if (parity_err || frame_err) begin
         if (err_q.size() == 0) begin
            cmp++; bad++;
            $display("FAIL spurious_err: got %0b expected none at %0t", {frame_err, parity_err}, $time);
         end else chk("err_kind", {frame_err, parity_err}, err_q.pop_front());
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_bit(input logic b, input int per);
      si = b; bit_en = 1'b1; tick();
      bit_en = 1'b0;
      repeat (per - 1) tick();
   endtask

   // model: frame error beats parity error; good word is taken unless an unread word blocks it
   task automatic send_frame(input logic [7:0] w, input logic flip, input logic stop, input int per);
      if (!stop) err_q.push_back(2'b10);
      else if (flip) err_q.push_back(2'b01);
      else if (ready || !m_pending) begin
         word_q.push_back(w); m_data = w; m_pending = !ready;
      end else m_ovr = 1'b1;
      send_bit(1'b0, per);
      for (int i = 7; i >= 0; i--) send_bit(w[i], per);
      send_bit((^w) ^ flip, per);
      send_bit(stop, per);
   endtask

   task automatic set_ready(input logic r);
      ready = r; tick();
      if (r) m_pending = 1'b0;
   endtask

   task automatic check_status(input string nm);
      bit_en = 1'b0; si = 1'b1;
      tick(); tick();
      chk({nm, ".busy"}, busy, 0);
      chk({nm, ".overrun"}, overrun, m_ovr);
      chk({nm, ".valid"}, valid, m_pending);
      chk({nm, ".data"}, data, m_data);
      chk({nm, ".words_left"}, word_q.size(), m_pending);
      chk({nm, ".errs_left"}, err_q.size(), 0);
   endtask

   task automatic do_reset(input string nm);
      clear_n = 1'b0; #2;
      chk({nm, ".rst_data"}, data, 0);
      chk({nm, ".rst_flags"}, {valid, busy, parity_err, frame_err, overrun}, 0);
      word_q.delete(); err_q.delete();
      m_pending = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
      tick(); clear_n = 1'b1; tick();
   endtask

   initial begin
      do_reset("reset");
      send_frame(8'hA5, 1'b0, 1'b1, 1); check_status("good_a5");
      send_frame(8'h3C, 1'b0, 1'b1, 1); check_status("good_3c");
      send_frame(8'hA5, 1'b1, 1'b1, 1); check_status("parity");
      send_frame(8'h3C, 1'b0, 1'b0, 1); check_status("frame");
      send_frame(8'h3C, 1'b1, 1'b0, 2); check_status("both_err");
      set_ready(1'b0);
      send_frame(8'hA5, 1'b0, 1'b1, 1);
      send_frame(8'h5A, 1'b0, 1'b1, 1); check_status("overrun");
      set_ready(1'b1); check_status("overrun_drain");
      send_frame(8'hA5, 1'b0, 1'b1, 4); check_status("slow_a5");
      send_bit(1'b0, 1);
      for (int i = 7; i >= 4; i--) send_bit(1'b1, 1);
      chk("midframe.busy", busy, 1);
      do_reset("midframe");
      send_frame(8'h81, 1'b0, 1'b1, 1); check_status("after_reset");
      send_frame(8'h42, 1'b0, 1'b1, 1);
      send_frame(8'h24, 1'b0, 1'b1, 1); check_status("back_to_back");
      for (int f = 0; f < 60; f++) begin
         if ($urandom_range(0, 3) == 0) set_ready(1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) send_bit(1'b1, 1);
         send_frame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0,
                    $urandom_range(1, 3));
         check_status("random");
      end
      set_ready(1'b1); check_status("final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule

// File: doc/sipo_frame_rx.md
SIPO_FRAME_RX -- requirements
Module: sipo_frame_rx

Interface
REQ-001 The block SHALL have parameter n, default 8, giving the data bits per frame (n >= 2).
REQ-002 The block SHALL have clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have clear_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have si, input, 1 bit: serial line; idles high.
REQ-005 The block SHALL have bit_en, input, 1 bit: bit strobe; si is sampled only on clk edges where bit_en=1.
REQ-006 The block SHALL have data, output, n bits: received word.
REQ-007 The block SHALL have valid, output, 1 bit: data holds an unconsumed word.
REQ-008 The block SHALL have ready, input, 1 bit: consumer accepts data when valid and ready are both 1 on a clk edge.
REQ-009 The block SHALL have busy, output, 1 bit: high in any state other than IDLE.
REQ-010 The block SHALL have parity_err, output, 1 bit: one-clk pulse.
REQ-011 The block SHALL have frame_err, output, 1 bit: one-clk pulse.
REQ-012 The block SHALL have overrun, output, 1 bit: sticky flag.

Function
REQ-013 The frame format SHALL be: start bit 0, n data bits MSB first, even parity bit, stop bit 1.
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY and STOP; it does nothing on edges where bit_en=0.
REQ-015 IDLE: si=0 sampled SHALL go to DATA, clear the bit counter and clear the shift register; si=1 SHALL stay in IDLE.
REQ-016 DATA: each sample SHALL shift left, with si entering the LSB, and increment the counter; after the nth sample the FSM SHALL go to PARITY.
REQ-017 PARITY: the FSM SHALL store the sample, then go to STOP.
REQ-018 STOP: the FSM SHALL return to IDLE in all cases.
REQ-019 In STOP, a stop sample of 0 SHALL pulse frame_err on the next cycle and discard the word.
REQ-020 In STOP, if the XOR of the data bits and the parity bit is 1, the block SHALL pulse parity_err on the next cycle and discard the word.
REQ-021 If frame_err and parity_err conditions are both true, only frame_err SHALL pulse.
REQ-022 A good frame SHALL load data and set valid on the clk edge that samples the stop bit, so valid is visible in the cycle after that edge.
REQ-023 A valid&&ready edge SHALL clear valid in the next cycle, unless a good frame completes on the same edge, in which case data is replaced and valid stays 1.
REQ-024 A good frame completing while valid=1 and ready=0 SHALL set overrun and leave data and valid unchanged; the new word is dropped.
REQ-025 overrun SHALL clear only on reset.
REQ-026 data SHALL hold its value while valid=1, and SHALL not change except on a good-frame load.
REQ-027 The bit counter SHALL be ceil(log2(n+1)) bits wide and SHALL never wrap within a frame.
REQ-028 A start bit arriving in the same sample slot as the return to IDLE SHALL NOT be detected; the next bit_en sample in IDLE is the earliest start.

Reset
REQ-029 clear_n=0 SHALL immediately force state IDLE, counter 0, shift register 0, data 0, valid 0, busy 0, parity_err 0, frame_err 0 and overrun 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no error pulse.
REQ-031 After reset release, reception SHALL resume at the first si=0 sample.

Structure
REQ-032 A shared package SHALL hold the state enumeration and the constant PARITY_EVEN=1.
REQ-033 The block SHALL have one sub-module, sipo_shift: n-bit shift-left register with load-clear and shift-enable.
REQ-034 The FSM, counter, output register and flags SHALL reside in sipo_frame_rx.

Verification
REQ-035 n=8, bit_en=1, ready=1, line 0,1,0,1,0,0,1,0,1,0,1 -> data=8'hA5 and valid=1 for one cycle after the stop edge; no errors.
REQ-036 Same frame with parity bit 1 -> parity_err pulses once, valid stays 0, and data keeps its prior value.
REQ-037 Frame for 8'h3C with stop bit 0 -> frame_err pulses once, and the FSM is in IDLE with busy=0 the next cycle.
REQ-038 ready=0, two good frames 8'hA5 then 8'h5A -> data=8'hA5, valid=1, overrun=1; raise ready -> valid clears and overrun stays 1.
REQ-039 bit_en high every 4th clk with frame 8'hA5 -> identical result to REQ-035; state is frozen on bit_en=0 cycles.
REQ-040 clear_n pulsed low after the 4th data bit, then a full 8'h81 frame -> no error pulses, data=8'h81, valid=1.
